// File: rtl/lif_pkg.sv
// Shared constants and arithmetic helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

    localparam int DEF_N_NEURONS   = 4;
    localparam int DEF_W           = 8;
    localparam int DEF_LEAK_SHIFT  = 1;
    localparam int DEF_REFRACT_CYC = 2;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Subtracting the shifted value rounds the leaked membrane up, so small v never decays to zero early.
    function automatic logic [31:0] ceil_leak(input logic [31:0] v, input int shift);
        return v - (v >> shift);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            return lim[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Control, write, monitor and spike-event signals of the LIF neuron array.
interface lif_neuron_array_if
    import lif_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int W         = DEF_W
);
    localparam int IW = idx_w(N_NEURONS);

    logic                 en;
    logic                 wr_en;
    logic [IW-1:0]        wr_addr;
    logic [W-1:0]         wr_data;
    logic [W-1:0]         thresh;
    logic [IW-1:0]        mon_sel;
    logic [W-1:0]         mon_state;
    logic                 spike_valid;
    logic [IW-1:0]        spike_id;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 sweep_done;

    modport master (
        output en, wr_en, wr_addr, wr_data, thresh, mon_sel,
        input  mon_state, spike_valid, spike_id, spike_vec, sweep_done
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, thresh, mon_sel,
        output mon_state, spike_valid, spike_id, spike_vec, sweep_done
    );

endinterface

// File: rtl/lif_update_core.sv
// Combinational single-neuron update: leak, add current, saturate, threshold, reset by subtraction.
module lif_update_core
    import lif_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic [W-1:0] v,
    input  logic [W-1:0] cur,
    input  logic [W-1:0] thresh,
    output logic [W-1:0] v_next,
    output logic         spike
);

    logic [31:0]  leaked_s;
    logic [31:0]  sum32_s;
    logic [W-1:0] sum_s;

    // Saturated sum, then fire when a non-zero threshold is reached.
    always_comb begin
        leaked_s = ceil_leak(32'(v), LEAK_SHIFT);
        sum32_s  = sat_add(leaked_s, 32'(cur), W);
        sum_s    = sum32_s[W-1:0];
        if ((thresh != {W{1'b0}}) && (sum_s >= thresh)) begin
            spike  = 1'b1;
            v_next = sum_s - thresh;
        end else begin
            spike  = 1'b0;
            v_next = sum_s;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire array: one neuron update per enabled cycle.
// Optional refractory period is built when LIF_REFRACTORY_EN is defined.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS   = DEF_N_NEURONS,
    parameter int W           = DEF_W,
    parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
    parameter int REFRACT_CYC = DEF_REFRACT_CYC
) (
    input logic               clk,
    input logic               rst,
    lif_neuron_array_if.slave bus
);

    localparam int IW = idx_w(N_NEURONS);

    logic [IW-1:0]        ptr_r;
    logic [W-1:0]         v_r   [N_NEURONS];
    logic [W-1:0]         cur_r [N_NEURONS];
    logic [N_NEURONS-1:0] acc_r;
    logic [W-1:0]         mon_state_r;
    logic                 spike_valid_r;
    logic [IW-1:0]        spike_id_r;
    logic [N_NEURONS-1:0] spike_vec_r;
    logic                 sweep_done_r;

    logic [W-1:0]         core_v_s;
    logic                 core_spike_s;
    logic [W-1:0]         upd_v_s;
    logic                 upd_spike_s;

    lif_update_core #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_core (
        .v      (v_r[ptr_r]),
        .cur    (cur_r[ptr_r]),
        .thresh (bus.thresh),
        .v_next (core_v_s),
        .spike  (core_spike_s)
    );

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRACT_CYC < 1) ? 1 : $clog2(REFRACT_CYC + 1);

    logic [RW-1:0] refr_r [N_NEURONS];

    // A refractory neuron ignores its input, stays at zero and cannot fire.
    always_comb begin
        if (refr_r[ptr_r] != {RW{1'b0}}) begin
            upd_v_s     = {W{1'b0}};
            upd_spike_s = 1'b0;
        end else begin
            upd_v_s     = core_v_s;
            upd_spike_s = core_spike_s;
        end
    end

    // Per-neuron count of remaining refractory updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                refr_r[i] <= {RW{1'b0}};
            end
        end else if (bus.en) begin
            if (refr_r[ptr_r] != {RW{1'b0}}) begin
                refr_r[ptr_r] <= refr_r[ptr_r] - RW'(1);
            end else if (core_spike_s) begin
                refr_r[ptr_r] <= RW'(REFRACT_CYC);
            end else begin
                refr_r[ptr_r] <= refr_r[ptr_r];
            end
        end else begin
            refr_r[ptr_r] <= refr_r[ptr_r];
        end
    end
`else
    // Without the refractory feature the core result is used directly.
    always_comb begin
        upd_v_s     = core_v_s;
        upd_spike_s = core_spike_s;
    end
`endif

    // Neuron state, current registers, sweep bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r         <= {IW{1'b0}};
            acc_r         <= {N_NEURONS{1'b0}};
            mon_state_r   <= {W{1'b0}};
            spike_valid_r <= 1'b0;
            spike_id_r    <= {IW{1'b0}};
            spike_vec_r   <= {N_NEURONS{1'b0}};
            sweep_done_r  <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_r[i]   <= {W{1'b0}};
                cur_r[i] <= {W{1'b0}};
            end
        end else begin
            // The core already read the old current, so a same-cycle write lands on the next update.
            if (bus.wr_en) begin
                cur_r[bus.wr_addr] <= bus.wr_data;
            end else begin
                cur_r[bus.wr_addr] <= cur_r[bus.wr_addr];
            end
            if (bus.en) begin
                v_r[ptr_r]    <= upd_v_s;
                spike_valid_r <= upd_spike_s;
                spike_id_r    <= ptr_r;
                if (ptr_r == IW'(N_NEURONS - 1)) begin
                    ptr_r        <= {IW{1'b0}};
                    acc_r        <= {N_NEURONS{1'b0}};
                    spike_vec_r  <= acc_r | ({{(N_NEURONS-1){1'b0}}, upd_spike_s} << ptr_r);
                    sweep_done_r <= 1'b1;
                end else begin
                    ptr_r         <= ptr_r + IW'(1);
                    acc_r[ptr_r]  <= upd_spike_s;
                    sweep_done_r  <= 1'b0;
                end
            end else begin
                spike_valid_r <= 1'b0;
                sweep_done_r  <= 1'b0;
            end
            mon_state_r <= v_r[bus.mon_sel];
        end
    end

    assign bus.mon_state   = mon_state_r;
    assign bus.spike_valid = spike_valid_r;
    assign bus.spike_id    = spike_id_r;
    assign bus.spike_vec   = spike_vec_r;
    assign bus.sweep_done  = sweep_done_r;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios plus randomized traffic against a behavioural model.
module tb_lif_neuron_array;
    import lif_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
`ifdef LIF_REFRACTORY_EN
    localparam int REFR = 2;
`else
    localparam int REFR = 0;
`endif
    localparam int PERIOD = 4 * (REFR + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lif_neuron_array_if #(.N_NEURONS(N), .W(W)) bus ();

    lif_neuron_array #(
        .N_NEURONS   (N),
        .W           (W),
        .LEAK_SHIFT  (1),
        .REFRACT_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: membranes, currents, refractory counts, spikes of the current sweep.
    int m_v   [N];
    int m_i   [N];
    int m_ref [N];
    int m_acc [N];
    int m_ptr;
    int e_mon, e_sv, e_id, e_vec, e_sd;

    logic [7:0] tbl [8] = '{8'd100, 8'd150, 8'd175, 8'd188, 8'd194, 8'd197, 8'd199, 8'd0};

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_i[i] = 0; m_ref[i] = 0; m_acc[i] = 0;
        end
        m_ptr = 0; e_mon = 0; e_sv = 0; e_id = 0; e_vec = 0; e_sd = 0;
    endtask

    // Applies the rules of one clock edge using the inputs currently driven.
    task automatic model_edge();
        int p, s, fire;
        e_mon = m_v[bus.mon_sel];
        if (bus.en) begin
            p = m_ptr;
            if (m_ref[p] > 0) begin
                m_ref[p] = m_ref[p] - 1;
                s = 0;
                fire = 0;
            end else begin
                s = (m_v[p] + 1) / 2 + m_i[p];
                if (s > 255) s = 255;
                fire = (bus.thresh != 0 && s >= int'(bus.thresh)) ? 1 : 0;
                if (fire != 0) begin
                    s = s - int'(bus.thresh);
                    m_ref[p] = REFR;
                end
            end
            m_v[p] = s;
            m_acc[p] = fire;
            e_sv = fire;
            e_id = p;
            if (p == N - 1) begin
                e_vec = 0;
                for (int i = 0; i < N; i++) begin
                    e_vec = e_vec + (m_acc[i] << i);
                    m_acc[i] = 0;
                end
                e_sd = 1;
                m_ptr = 0;
            end else begin
                e_sd = 0;
                m_ptr = p + 1;
            end
        end else begin
            e_sv = 0;
            e_sd = 0;
        end
        if (bus.wr_en) m_i[bus.wr_addr] = int'(bus.wr_data);
    endtask

    function automatic logic [15:0] got_word();
        return {bus.mon_state, bus.spike_valid, bus.spike_valid ? bus.spike_id : 2'd0,
                bus.spike_vec, bus.sweep_done};
    endfunction

    function automatic logic [15:0] exp_word();
        logic [1:0] id;
        id = (e_sv != 0) ? e_id[1:0] : 2'd0;
        return {e_mon[7:0], e_sv[0], id, e_vec[3:0], e_sd[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'd0;
        bus.thresh = 8'd0; bus.mon_sel = 2'd0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({got_word(), bus.spike_id} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", {got_word(), bus.spike_id});
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_leak_spike();
        int first;
        reset_dut();
        bus.thresh = 8'd200; bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 8'd100;
        step();
        bus.wr_en = 1'b0; bus.en = 1'b1;
        first = 0;
        for (int e = 1; e <= 36; e++) begin
            step();
            vectors++;
            if (got_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL leak_model e=%0d: got %h expected %h", e, got_word(), exp_word());
            end
            if (e % 4 == 2 && e <= 30) begin
                vectors++;
                if (bus.mon_state !== tbl[(e - 2) / 4]) begin
                    miscompares++;
                    $display("FAIL leak_table e=%0d: got %0d expected %0d", e, bus.mon_state, tbl[(e - 2) / 4]);
                end
            end
            if (bus.spike_valid === 1'b1 && first == 0) first = e;
        end
        vectors++;
        if (first != 29) begin
            miscompares++;
            $display("FAIL leak_first_spike: got edge %0d expected 29", first);
        end
    endtask

    task automatic test_thresh_zero();
        reset_dut();
        bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 8'd255;
        step();
        bus.wr_en = 1'b0; bus.en = 1'b1; bus.mon_sel = 2'd2;
        for (int e = 1; e <= 16; e++) begin
            step();
            vectors++;
            if (got_word() !== exp_word() || bus.spike_valid !== 1'b0 ||
                (e >= 4 && bus.mon_state !== 8'd255)) begin
                miscompares++;
                $display("FAIL thresh_zero e=%0d: got %h expected %h (mon 255 from e=4, no spike)",
                         e, got_word(), exp_word());
            end
        end
    endtask

    task automatic test_periodic();
        int last, count;
        logic [3:0] want_vec;
        reset_dut();
        bus.thresh = 8'd200; bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 8'd200;
        step();
        bus.wr_en = 1'b0; bus.en = 1'b1;
        last = 0; count = 0;
        for (int e = 1; e <= 48; e++) begin
            step();
            vectors++;
            if (got_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL periodic_model e=%0d: got %h expected %h", e, got_word(), exp_word());
            end
            if (bus.spike_valid === 1'b1) begin
                count++;
                vectors++;
                if (bus.spike_id !== 2'd1 || (last != 0 && e - last != PERIOD)) begin
                    miscompares++;
                    $display("FAIL periodic_spike e=%0d: id %0d gap %0d expected id 1 gap %0d",
                             e, bus.spike_id, e - last, PERIOD);
                end
                last = e;
            end
            if (bus.sweep_done === 1'b1) begin
                want_vec = (REFR == 0 || (e - 4) % 12 == 0) ? 4'b0010 : 4'b0000;
                vectors++;
                if (bus.spike_vec !== want_vec) begin
                    miscompares++;
                    $display("FAIL periodic_vec e=%0d: got %b expected %b", e, bus.spike_vec, want_vec);
                end
            end
        end
        vectors++;
        if (count != 48 / PERIOD) begin
            miscompares++;
            $display("FAIL periodic_count: got %0d expected %0d", count, 48 / PERIOD);
        end
    endtask

    task automatic test_en_toggle();
        int enabled;
        logic want_sd;
        logic [3:0] pat;
        reset_dut();
        bus.thresh = 8'd120;
        pat = 4'b1001;
        enabled = 0;
        for (int e = 0; e < 32; e++) begin
            bus.en = pat[e % 4];
            bus.wr_en = ($urandom_range(0, 1) == 0);
            bus.wr_addr = 2'($urandom_range(0, 3));
            bus.wr_data = 8'($urandom_range(0, 255));
            bus.mon_sel = 2'($urandom_range(0, 3));
            if (bus.en) enabled++;
            want_sd = bus.en && (enabled % 4 == 0);
            step();
            vectors++;
            if (got_word() !== exp_word() || bus.sweep_done !== want_sd) begin
                miscompares++;
                $display("FAIL en_toggle e=%0d: got %h expected %h sweep_done want %b",
                         e, got_word(), exp_word(), want_sd);
            end
        end
    endtask

    task automatic test_same_cycle_write();
        reset_dut();
        bus.thresh = 8'd200; bus.en = 1'b1; bus.mon_sel = 2'd3;
        for (int e = 1; e <= 10; e++) begin
            bus.wr_en = (e == 4);
            bus.wr_addr = 2'd3; bus.wr_data = 8'd50;
            step();
            vectors++;
            if (got_word() !== exp_word() ||
                (e == 5 && bus.mon_state !== 8'd0) || (e == 9 && bus.mon_state !== 8'd50)) begin
                miscompares++;
                $display("FAIL same_cycle_write e=%0d: got %h expected %h", e, got_word(), exp_word());
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        reset_dut();
        bus.thresh = 8'd200; bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 8'd200;
        step();
        bus.wr_en = 1'b0; bus.en = 1'b1; bus.mon_sel = 2'd1;
        for (int e = 1; e <= 6; e++) step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({got_word(), bus.spike_id} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_mid_sweep: got %h expected 0", {got_word(), bus.spike_id});
        end
        #1;
        rst = 1'b0;
        model_clear();
        for (int e = 1; e <= 8; e++) begin
            step();
            vectors++;
            if (got_word() !== exp_word() || bus.sweep_done !== (e % 4 == 0)) begin
                miscompares++;
                $display("FAIL post_reset_sweep e=%0d: got %h expected %h", e, got_word(), exp_word());
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int e = 0; e < 400; e++) begin
            bus.en = ($urandom_range(0, 3) != 0);
            bus.wr_en = ($urandom_range(0, 2) == 0);
            bus.wr_addr = 2'($urandom_range(0, 3));
            bus.wr_data = 8'($urandom_range(0, 255));
            bus.thresh = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.mon_sel = 2'($urandom_range(0, 3));
            step();
            vectors++;
            if (got_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL random e=%0d: got %h expected %h", e, got_word(), exp_word());
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_clear();
        test_reset();
        test_leak_spike();
        test_thresh_zero();
        test_periodic();
        test_en_toggle();
        test_same_cycle_write();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of time-multiplexed neurons (power of two, 2..16).
REQ-002 SHALL have parameter W, default 8, membrane/current/threshold width in bits.
REQ-003 SHALL have parameter LEAK_SHIFT, default 1, leak factor: v_leaked = v - (v >> LEAK_SHIFT).
REQ-004 SHALL have parameter REFRACT_CYC, default 2, refractory length in own-neuron updates; used only with the Configuration macro.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  input  1  high: advance one neuron update per cycle; low: freeze.
REQ-008 SHALL have port wr_en  input  1  write input current register.
REQ-009 SHALL have port wr_addr  input  clog2(N_NEURONS)  neuron index for write.
REQ-010 SHALL have port wr_data  input  W  input current value.
REQ-011 SHALL have port thresh  input  W  firing threshold; 0 disables firing.
REQ-012 SHALL have port mon_sel  input  clog2(N_NEURONS)  neuron whose membrane is monitored.
REQ-013 SHALL have port mon_state  output  W  registered membrane of neuron mon_sel.
REQ-014 SHALL have ports spike_valid  output  1, spike_id  output  clog2(N_NEURONS): one-cycle spike event and its neuron index.
REQ-015 SHALL have ports spike_vec  output  N_NEURONS (spikes of last complete sweep) and sweep_done  output  1 (one-cycle pulse).

Function
REQ-016 Index pointer ptr SHALL step 0..N_NEURONS-1 and wrap to 0, advancing only on cycles with en=1.
REQ-017 On each en=1 cycle neuron ptr SHALL compute sum = ceil-leak(v) + I[ptr] in W+1 bits, saturated to 2^W-1.
REQ-018 If thresh!=0 and sum >= thresh, the neuron SHALL spike and store v = sum - thresh (reset by subtraction); otherwise v = sum.
REQ-019 spike_valid SHALL assert exactly one cycle after the spiking update, with spike_id = that ptr; latency 1 cycle.
REQ-020 sweep_done SHALL pulse one cycle after the update of neuron N_NEURONS-1; spike_vec SHALL update in the same cycle with the sweep's accumulated spikes and hold until next sweep_done.
REQ-021 en=0 SHALL freeze ptr, membranes and sweep accumulator; spike_valid and sweep_done SHALL be 0.
REQ-022 A write to neuron k in the same cycle k updates SHALL not affect that update; the new current applies from k's next update.
REQ-023 mon_state SHALL reflect v[mon_sel] one cycle after any change of v or mon_sel.

Reset
REQ-024 rst SHALL asynchronously clear all membranes, currents, ptr, sweep accumulator, refractory counters and every output to 0.
REQ-025 Reset mid-sweep SHALL discard the partial sweep; the first sweep_done after release follows N_NEURONS enabled cycles.

Configuration
REQ-026 Macro LIF_REFRACTORY_EN defined: after a spike the neuron SHALL, for its next REFRACT_CYC own updates, ignore input, hold v=0 and not spike.
REQ-027 Macro undefined: no refractory counters SHALL be built and REFRACT_CYC SHALL have no effect.

Structure
REQ-028 Package lif_pkg SHALL hold default parameter constants, the index-width function and the saturating-add/leak functions.
REQ-029 Per-neuron arithmetic (leak, add, saturate, compare, subtract) SHALL be sub-module lif_update_core; lif_neuron_array holds state arrays, pointer and outputs.

Verification (N_NEURONS=4, W=8, LEAK_SHIFT=1, thresh=200, en=1 unless stated)
REQ-030 I[0]=100, others 0 -> v0 after each own update 100,150,175,188,194,197,199 then spike on 8th update, v0=0, spike_id=0.
REQ-031 thresh=0, I[2]=255 -> mon_sel=2 reads 255 after first update and stays 255; no spike_valid.
REQ-032 I[1]=200 -> spike_id=1 every 4 cycles, spike_vec=4'b0010 each sweep; with LIF_REFRACTORY_EN, REFRACT_CYC=2 -> every 12 cycles.
REQ-033 en toggled 1,0,0,1 -> ptr advances only on en=1 cycles; sweep_done after 4 enabled cycles.
REQ-034 wr_en to neuron 3 in the cycle ptr=3 with wr_data=50 (old 0) -> that update uses 0; next update of 3 uses 50.
REQ-035 rst asserted at ptr=2 mid-sweep -> all outputs 0 immediately; first sweep_done 4 enabled cycles after release.
